// File: rtl/multi_ch_echo_scan_pkg.sv
// Shared definitions for the multi-channel echo scanner.
// Holds the scan FSM state encoding, the default timing constants (in
// clk_50M cycles) and the channel search helper used by the top level.
package us_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    FIRE   = 3'd2,
    BLANK  = 3'd3,
    LISTEN = 3'd4,
    REPORT = 3'd5,
    NEXT   = 3'd6
  } state_e;

  localparam int DEF_SETTLE_CYC = 50;
  localparam int DEF_BLANK_CYC  = 500;
  localparam int DEF_WINDOW_CYC = 100000;
  localparam int MAX_CH         = 16;

  // Lowest set bit of mask at index >= from; 5'd16 means "none left".
  function automatic logic [4:0] find_from(input logic [15:0] mask, input logic [4:0] from);
    logic [4:0] res;
    res = 5'd16;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (5'(i) >= from)) begin
        res = 5'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/multi_ch_echo_scan_if.sv
// Data-path bundle of the echo scanner: the incoming correlation magnitude
// stream and the outgoing per-channel result handshake.
//   master : the scanner (consumes magnitudes, produces results)
//   slave  : the environment (drives magnitudes, accepts results)
interface multi_ch_echo_scan_if #(
  parameter int CH_W  = 2,
  parameter int MAG_W = 18,
  parameter int TOF_W = 20
);
  logic             mag_valid;
  logic [MAG_W-1:0] mag_data;
  logic             res_valid;
  logic             res_ready;
  logic [CH_W-1:0]  res_ch;
  logic             res_hit;
  logic [TOF_W-1:0] res_tof;
  logic [MAG_W-1:0] res_peak;

  modport master (
    input  mag_valid, mag_data, res_ready,
    output res_valid, res_ch, res_hit, res_tof, res_peak
  );

  modport slave (
    output mag_valid, mag_data, res_ready,
    input  res_valid, res_ch, res_hit, res_tof, res_peak
  );
endinterface

// File: rtl/multi_ch_echo_scan_peak_track.sv
// Peak / time-of-flight tracker for one listen window.
// Ports: clk_50M, rst (sync, active-high); clear_i restarts tracking;
// sample_i/data_i/tof_i present one evaluated sample; thr_i is the hit
// threshold; peak_o/tof_o hold the earliest strict maximum, hit_o = peak >= thr.
module echo_peak_track #(
  parameter int MAG_W = 18,
  parameter int TOF_W = 20
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             sample_i,
  input  logic [MAG_W-1:0] data_i,
  input  logic [TOF_W-1:0] tof_i,
  input  logic [MAG_W-1:0] thr_i,
  output logic [MAG_W-1:0] peak_o,
  output logic [TOF_W-1:0] tof_o,
  output logic             hit_o
);
  logic [MAG_W-1:0] peak_q;
  logic [TOF_W-1:0] tof_q;

  // Peak register: strict '>' so equal later samples keep the earlier tof.
  always_ff @(posedge clk_50M) begin
    if (rst || clear_i) begin
      peak_q <= {MAG_W{1'b0}};
      tof_q  <= {TOF_W{1'b1}};
    end else if (sample_i && (data_i > peak_q)) begin
      peak_q <= data_i;
      tof_q  <= tof_i;
    end
  end

  assign peak_o = peak_q;
  assign tof_o  = tof_q;
  assign hit_o  = (peak_q >= thr_i);
endmodule

// File: rtl/multi_ch_echo_scan.sv
// Multi-channel ultrasonic echo scanner.
// Ports: clk_50M, rst (sync, active-high); scan_start/ch_enable/
// corr_threshold start a scan; ch_sel/launch_cmd/listen drive the front
// end; bus carries the magnitude stream and the per-channel result
// handshake; busy/scan_done report scan progress.
// Per enabled channel: SETTLE -> FIRE (tof 0) -> BLANK -> LISTEN -> REPORT.
module multi_ch_echo_scan
  import us_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int MAG_W      = 18,
  parameter int TOF_W      = 20,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int BLANK_CYC  = DEF_BLANK_CYC,
  parameter int WINDOW_CYC = DEF_WINDOW_CYC,
  parameter int EARLY_STOP = 0,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic             scan_start,
  input  logic [N_CH-1:0]  ch_enable,
  input  logic [MAG_W-1:0] corr_threshold,
  multi_ch_echo_scan_if.master bus,
  output logic [CH_W-1:0]  ch_sel,
  output logic             launch_cmd,
  output logic             listen,
  output logic             busy,
  output logic             scan_done
);
  state_e           state_q, state_d;
  logic [31:0]      cnt_q;
  logic [15:0]      mask_q;
  logic [MAG_W-1:0] thr_q;
  logic [CH_W-1:0]  ch_q;
  logic [TOF_W-1:0] tof_q;
  logic             done_q;
  logic             res_valid_q, res_hit_q;
  logic [CH_W-1:0]  res_ch_q;
  logic [TOF_W-1:0] res_tof_q;
  logic [MAG_W-1:0] res_peak_q;

  logic             accept_s, start_ok_s, sample_s, early_hit_s, xfer_s;
  logic [4:0]       first_s, next_s;
  logic [MAG_W-1:0] trk_peak_s;
  logic [TOF_W-1:0] trk_tof_s;
  logic             trk_hit_s;

  assign accept_s    = (state_q == IDLE) && scan_start;
  assign start_ok_s  = accept_s && (|ch_enable);
  assign sample_s    = (state_q == LISTEN) && bus.mag_valid;
  assign early_hit_s = (EARLY_STOP != 0) && sample_s && (bus.mag_data >= thr_q);
  assign xfer_s      = res_valid_q && bus.res_ready;
  assign first_s     = find_from(16'(ch_enable), 5'd0);
  assign next_s      = find_from(mask_q, 5'(ch_q) + 5'd1);

  // Next-state logic; phase lengths are measured with cnt_q (cycles in state).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok_s) state_d = SETTLE; else state_d = IDLE;
      SETTLE:  if (cnt_q == 32'(SETTLE_CYC - 1)) state_d = FIRE; else state_d = SETTLE;
      FIRE:    state_d = BLANK;
      BLANK:   if (cnt_q == 32'(BLANK_CYC - 1)) state_d = LISTEN; else state_d = BLANK;
      LISTEN:  if ((cnt_q == 32'(WINDOW_CYC - 1)) || early_hit_s) state_d = REPORT;
               else state_d = LISTEN;
      REPORT:  if (xfer_s) state_d = NEXT; else state_d = REPORT;
      NEXT:    if (next_s != 5'd16) state_d = SETTLE; else state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, phase counter and saturating tof counter (tof 0 is the FIRE cycle).
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      tof_q   <= {TOF_W{1'b0}};
    end else begin
      state_q <= state_d;
      if (state_d != state_q) cnt_q <= 32'd0;
      else                    cnt_q <= cnt_q + 32'd1;
      if (state_d == FIRE)          tof_q <= {TOF_W{1'b0}};
      else if (tof_q != {TOF_W{1'b1}}) tof_q <= tof_q + TOF_W'(1);
    end
  end

  // Scan context: mask/threshold captured on acceptance, channel stepping, end pulse.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      mask_q <= 16'd0;
      thr_q  <= {MAG_W{1'b0}};
      ch_q   <= {CH_W{1'b0}};
      done_q <= 1'b0;
    end else begin
      done_q <= (accept_s && !(|ch_enable)) || ((state_q == NEXT) && (next_s == 5'd16));
      if (start_ok_s) begin
        mask_q <= 16'(ch_enable);
        thr_q  <= corr_threshold;
        ch_q   <= CH_W'(first_s);
      end else if ((state_q == NEXT) && (next_s != 5'd16)) begin
        ch_q <= CH_W'(next_s);
      end
    end
  end

  // Result register: loaded on the first REPORT cycle, held until accepted.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_ch_q    <= {CH_W{1'b0}};
      res_hit_q   <= 1'b0;
      res_tof_q   <= {TOF_W{1'b0}};
      res_peak_q  <= {MAG_W{1'b0}};
    end else if ((state_q == REPORT) && !res_valid_q) begin
      res_valid_q <= 1'b1;
      res_ch_q    <= ch_q;
      res_hit_q   <= trk_hit_s;
      res_tof_q   <= trk_hit_s ? trk_tof_s : {TOF_W{1'b1}};
      res_peak_q  <= trk_peak_s;
    end else if (xfer_s) begin
      res_valid_q <= 1'b0;
    end
  end

  echo_peak_track #(.MAG_W(MAG_W), .TOF_W(TOF_W)) u_track (
    .clk_50M  (clk_50M),
    .rst      (rst),
    .clear_i  (state_q == FIRE),
    .sample_i (sample_s),
    .data_i   (bus.mag_data),
    .tof_i    (tof_q),
    .thr_i    (thr_q),
    .peak_o   (trk_peak_s),
    .tof_o    (trk_tof_s),
    .hit_o    (trk_hit_s)
  );

  assign ch_sel       = ch_q;
  assign launch_cmd   = (state_q == FIRE);
  assign listen       = (state_q == LISTEN);
  assign busy         = (state_q != IDLE);
  assign scan_done    = done_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_ch    = res_ch_q;
  assign bus.res_hit   = res_hit_q;
  assign bus.res_tof   = res_tof_q;
  assign bus.res_peak  = res_peak_q;
endmodule

// File: tb/tb_multi_ch_echo_scan.sv
// Randomized scoreboard bench for multi_ch_echo_scan (N_CH=4, SETTLE=2,
// BLANK=10, WINDOW=100). A second instance with EARLY_STOP=1 is started
// only in the early-stop scenario.
module tb_multi_ch_echo_scan;
  localparam int N_CH = 4, CH_W = 2, MAG_W = 18, TOF_W = 20;
  localparam int S = 2, B = 10, W = 100, MAXT = B + W + 5;
  localparam int TOF_ONES = (1 << TOF_W) - 1;

  typedef struct { int ch; int hit; int tof; int peak; } exp_t;

  logic clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  logic             rst = 1'b1, scan_start = 1'b0, scan_start1 = 1'b0;
  logic [N_CH-1:0]  ch_enable = '0;
  logic [MAG_W-1:0] corr_threshold = '0;
  logic [CH_W-1:0]  ch_sel, ch_sel1;
  logic             launch_cmd, launch1, listen, listen1, busy, busy1, scan_done, scan_done1;

  multi_ch_echo_scan_if #(.CH_W(CH_W), .MAG_W(MAG_W), .TOF_W(TOF_W)) bus0 ();
  multi_ch_echo_scan_if #(.CH_W(CH_W), .MAG_W(MAG_W), .TOF_W(TOF_W)) bus1 ();

  multi_ch_echo_scan #(.N_CH(N_CH), .MAG_W(MAG_W), .TOF_W(TOF_W), .SETTLE_CYC(S),
    .BLANK_CYC(B), .WINDOW_CYC(W), .EARLY_STOP(0)) dut (
    .clk_50M(clk_50M), .rst(rst), .scan_start(scan_start), .ch_enable(ch_enable),
    .corr_threshold(corr_threshold), .bus(bus0), .ch_sel(ch_sel), .launch_cmd(launch_cmd),
    .listen(listen), .busy(busy), .scan_done(scan_done));

  multi_ch_echo_scan #(.N_CH(N_CH), .MAG_W(MAG_W), .TOF_W(TOF_W), .SETTLE_CYC(S),
    .BLANK_CYC(B), .WINDOW_CYC(W), .EARLY_STOP(1)) dut_es (
    .clk_50M(clk_50M), .rst(rst), .scan_start(scan_start1), .ch_enable(ch_enable),
    .corr_threshold(corr_threshold), .bus(bus1), .ch_sel(ch_sel1), .launch_cmd(launch1),
    .listen(listen1), .busy(busy1), .scan_done(scan_done1));

  int checks = 0, errors = 0;
  exp_t q0[$], q1[$];
  bit prof_v [0:N_CH-1][0:MAXT-1];
  int prof_d [0:N_CH-1][0:MAXT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic set_mag(input bit v, input int d);
    bus0.mag_valid = v; bus0.mag_data = MAG_W'(d);
    bus1.mag_valid = v; bus1.mag_data = MAG_W'(d);
  endtask

  // Reference: scan the listen window (tof B+1..B+W) for the earliest strict maximum.
  function automatic exp_t model(input int ch, input int thr, input bit early);
    exp_t e;
    int best;
    e.ch = ch; e.peak = 0; best = TOF_ONES;
    for (int t = B + 1; t <= B + W; t++) begin
      if (prof_v[ch][t]) begin
        if (prof_d[ch][t] > e.peak) begin e.peak = prof_d[ch][t]; best = t; end
        if (early && prof_d[ch][t] >= thr) break;
      end
    end
    e.hit = (e.peak >= thr) ? 1 : 0;
    e.tof = e.hit ? best : TOF_ONES;
    return e;
  endfunction

  // kind 0: wide values, 1: all below threshold, 2: no valid listen samples.
  task automatic gen_profile(input int ch, input int kind, input int thr);
    for (int t = 0; t < MAXT; t++) begin
      prof_v[ch][t] = ($urandom_range(0, 1) == 1);
      if (t <= B || t > B + W) prof_d[ch][t] = $urandom_range(0, 200000);
      else if (kind == 0) prof_d[ch][t] = $urandom_range(0, 4000);
      else if (kind == 1) prof_d[ch][t] = $urandom_range(0, thr - 1);
      else begin prof_v[ch][t] = 1'b0; prof_d[ch][t] = $urandom_range(0, 4000); end
    end
  endtask

  task automatic noise_profile(input int ch, input int maxv);
    for (int t = 0; t < MAXT; t++) begin
      prof_v[ch][t] = (t > B && t <= B + W);
      prof_d[ch][t] = $urandom_range(0, maxv);
    end
  endtask

  task automatic run_scan(input logic [3:0] mask, input int thr, input int stall,
                          input bit poke, input bit es);
    int chs[$];
    int cnt, wait_n;
    bit bad, got, early_l;
    for (int c = 0; c < N_CH; c++) if (mask[c]) chs.push_back(c);
    scan_start = 1'b1; scan_start1 = es; ch_enable = mask; corr_threshold = MAG_W'(thr);
    next_cyc();
    scan_start = 1'b0; scan_start1 = 1'b0;
    ch_enable = 4'($urandom_range(0, 15)); corr_threshold = MAG_W'($urandom_range(0, 9000));
    if (mask == 4'd0) begin
      chk("empty_done_pulse", scan_done, 1);
      chk("empty_no_launch", launch_cmd, 0);
      next_cyc();
      chk("empty_done_once", scan_done, 0);
      chk("empty_idle", busy, 0);
      return;
    end
    foreach (chs[i]) begin
      wait_n = (i == 0) ? S : S + 1;
      early_l = 1'b0;
      for (int k = 0; k < wait_n; k++) begin
        if (launch_cmd) early_l = 1'b1;
        next_cyc();
      end
      chk("launch_not_early", early_l, 0);
      chk("launch_latency", launch_cmd, 1);
      chk("ch_sel", ch_sel, chs[i]);
      chk("busy_in_scan", busy, 1);
      q0.push_back(model(chs[i], thr, 1'b0));
      if (es) q1.push_back(model(chs[i], thr, 1'b1));
      bad = 1'b0;
      for (int t = 0; t < MAXT; t++) begin
        set_mag(prof_v[chs[i]][t], prof_d[chs[i]][t]);
        scan_start = (poke && t == 5);
        if (poke && t == 5) ch_enable = 4'b1111;
        if (listen !== ((t > B && t <= B + W) ? 1'b1 : 1'b0)) bad = 1'b1;
        if (es && t == 20) chk("es_listen_at_hit", listen1, 1);
        if (es && t == 21) chk("es_listen_after_hit", listen1, 0);
        next_cyc();
      end
      scan_start = 1'b0;
      set_mag(1'b0, 0);
      chk("listen_gate", bad, 0);
      for (int k = 0; k < stall; k++) next_cyc();
      bus0.res_ready = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk_50M);
        if (bus0.res_valid && bus0.res_ready) begin got = 1'b1; break; end
      end
      chk("transfer_timeout", got, 1);
      next_cyc();
      bus0.res_ready = 1'b0;
      if (!got) return;
    end
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      cnt += int'(scan_done);
      next_cyc();
    end
    chk("scan_done_pulses", cnt, 1);
    chk("idle_after_scan", busy, 0);
  endtask

  // Scoreboard for the main instance: pop on every accepted result, check holding.
  logic [40:0] prev0;
  bit hold0 = 1'b0;
  exp_t e0;
  always @(negedge clk_50M) begin
    if (rst) begin
      hold0 = 1'b0;
    end else begin
      if (hold0) begin
        chk("res_valid_held", bus0.res_valid, 1);
        chk("res_payload_stable", {bus0.res_ch, bus0.res_hit, bus0.res_tof, bus0.res_peak}, prev0);
      end
      if (bus0.res_valid) begin
        chk("no_launch_while_pending", launch_cmd, 0);
        if (bus0.res_ready) begin
          hold0 = 1'b0;
          if (q0.size() == 0) chk("unexpected_result", q0.size(), 1);
          else begin
            e0 = q0.pop_front();
            chk("res_ch", bus0.res_ch, e0.ch);
            chk("res_hit", bus0.res_hit, e0.hit);
            chk("res_tof", bus0.res_tof, e0.tof);
            chk("res_peak", bus0.res_peak, e0.peak);
          end
        end else begin
          hold0 = 1'b1;
          prev0 = {bus0.res_ch, bus0.res_hit, bus0.res_tof, bus0.res_peak};
        end
      end else begin
        hold0 = 1'b0;
      end
    end
  end

  // Scoreboard for the early-stop instance (always ready).
  exp_t e1;
  always @(negedge clk_50M) begin
    if (!rst && bus1.res_valid && bus1.res_ready) begin
      if (q1.size() == 0) chk("es_unexpected_result", q1.size(), 1);
      else begin
        e1 = q1.pop_front();
        chk("es_res_ch", bus1.res_ch, e1.ch);
        chk("es_res_hit", bus1.res_hit, e1.hit);
        chk("es_res_tof", bus1.res_tof, e1.tof);
        chk("es_res_peak", bus1.res_peak, e1.peak);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int thr;
    logic [3:0] m;
    set_mag(1'b0, 0);
    bus0.res_ready = 1'b0;
    bus1.res_ready = 1'b1;
    repeat (3) next_cyc();
    chk("rst_busy", busy, 0);
    chk("rst_outputs", {ch_sel, launch_cmd, listen, scan_done, bus0.res_valid,
        bus0.res_ch, bus0.res_hit, bus0.res_tof, bus0.res_peak}, 0);
    rst = 1'b0;
    next_cyc();

    // Two enabled channels, one strong echo each at tof 40.
    noise_profile(0, 900); prof_d[0][40] = 5000;
    noise_profile(2, 900); prof_d[2][40] = 5000;
    run_scan(4'b0101, 1000, 0, 1'b0, 1'b0);

    // Equal samples at tof 20 and 30; also run the early-stop instance.
    noise_profile(0, 900); prof_d[0][20] = 1200; prof_d[0][30] = 1200;
    run_scan(4'b0001, 1000, 2, 1'b0, 1'b1);

    // Below-threshold window with a big echo inside blanking and after the window.
    noise_profile(1, 998); prof_d[1][60] = 999;
    prof_v[1][0] = 1'b1; prof_d[1][0] = 9000;
    prof_v[1][5] = 1'b1; prof_d[1][5] = 9000;
    prof_v[1][B + W + 1] = 1'b1; prof_d[1][B + W + 1] = 9000;
    run_scan(4'b0010, 1000, 0, 1'b0, 1'b0);

    // Long consumer stall between two channels.
    noise_profile(1, 3000); noise_profile(3, 3000);
    run_scan(4'b1010, 1000, 50, 1'b0, 1'b0);

    // Empty mask, then a start pulse issued mid-scan.
    run_scan(4'b0000, 1000, 0, 1'b0, 1'b0);
    noise_profile(2, 2000);
    run_scan(4'b0100, 1000, 1, 1'b1, 1'b0);

    // Reset in the middle of a listen window.
    noise_profile(1, 3000);
    scan_start = 1'b1; ch_enable = 4'b0010; corr_threshold = 18'd1000;
    next_cyc();
    scan_start = 1'b0;
    for (int k = 0; k < S + 50; k++) begin
      set_mag(prof_v[1][k], prof_d[1][k]);
      next_cyc();
    end
    chk("mid_scan_listening", listen, 1);
    rst = 1'b1;
    next_cyc();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_outputs", {ch_sel, launch_cmd, listen, scan_done, bus0.res_valid,
        bus0.res_ch, bus0.res_hit, bus0.res_tof, bus0.res_peak}, 0);
    rst = 1'b0;
    set_mag(1'b0, 0);
    next_cyc();
    noise_profile(3, 900); prof_d[3][77] = 1500;
    run_scan(4'b1000, 1000, 0, 1'b0, 1'b0);

    // Randomized scans.
    for (int r = 0; r < 10; r++) begin
      m = 4'($urandom_range(1, 15));
      thr = $urandom_range(1, 3000);
      for (int c = 0; c < N_CH; c++) gen_profile(c, $urandom_range(0, 2), thr);
      run_scan(m, thr, $urandom_range(0, 6), 1'b0, 1'b0);
    end

    repeat (5) next_cyc();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_ch_echo_scan.md
MULTI_CH_ECHO_SCAN -- requirements
Module: multi_ch_echo_scan

Interface
REQ-001 Parameter N_CH, default 4, number of transducer channels; legal range 1..16; CH_W = max(1, clog2(N_CH)).
REQ-002 Parameter MAG_W, default 18, width of the correlation magnitude and threshold.
REQ-003 Parameter TOF_W, default 20, width of the time-of-flight count in clk_50M cycles.
REQ-004 Parameters SETTLE_CYC (default 50), BLANK_CYC (default 500) and WINDOW_CYC (default 100000), all >= 1; EARLY_STOP (default 0) selects the listen-termination mode.
REQ-005 clk_50M  in  1  sole clock; one clock, all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 scan_start  in  1  one-cycle pulse that starts a scan over the enabled channels.
REQ-008 ch_enable  in  N_CH  channel enable mask, sampled on an accepted scan_start.
REQ-009 corr_threshold  in  MAG_W  hit threshold, sampled on an accepted scan_start.
REQ-010 mag_valid / mag_data  in  1 / MAG_W  unsigned correlation magnitude stream.
REQ-011 ch_sel  out  CH_W  active channel for the relay/mux; launch_cmd  out  1  one-cycle fire pulse; listen  out  1  listen-window gate.
REQ-012 res_valid  out  1, res_ready  in  1, res_ch  out  CH_W, res_hit  out  1, res_tof  out  TOF_W, res_peak  out  MAG_W: per-channel result handshake.
REQ-013 busy  out  1  high from an accepted scan_start until scan_done; scan_done  out  1  one-cycle end-of-scan pulse.

Function
REQ-014 The FSM SHALL have states IDLE, SETTLE, FIRE, BLANK, LISTEN, REPORT and NEXT.
REQ-015 In IDLE, scan_start SHALL be accepted; scan_start in any other state SHALL be ignored.
REQ-016 On acceptance with ch_enable == 0, the block SHALL pulse scan_done on the next cycle, issue no launch, and stay in IDLE.
REQ-017 Otherwise the block SHALL set ch_sel to the lowest enabled channel and spend exactly SETTLE_CYC cycles in SETTLE.
REQ-018 FIRE SHALL last one cycle with launch_cmd = 1; that cycle is tof = 0.
REQ-019 BLANK SHALL cover tof 1..BLANK_CYC; LISTEN SHALL cover tof BLANK_CYC+1..BLANK_CYC+WINDOW_CYC, with listen = 1 only in LISTEN.
REQ-020 Only samples with mag_valid = 1 in LISTEN SHALL be evaluated; samples in other states SHALL be discarded.
REQ-021 Peak SHALL update only on a strictly greater sample, so ties keep the earliest tof; res_tof is the tof of that sample.
REQ-022 res_hit SHALL be 1 iff peak >= the sampled threshold; if no hit, res_tof SHALL be all-ones and res_peak the maximum seen (0 if no valid sample).
REQ-023 If EARLY_STOP = 1, LISTEN SHALL end after the first sample >= threshold; that sample sets peak and tof.
REQ-024 The tof counter SHALL saturate at 2^TOF_W-1 and never wrap.
REQ-025 In REPORT, res_valid SHALL be held with stable payload until res_valid & res_ready; the transfer cycle SHALL go to NEXT.
REQ-026 NEXT SHALL select the next higher enabled channel and go to SETTLE, or pulse scan_done and go to IDLE if none remains.
REQ-027 Latency from scan_start to the first launch_cmd SHALL be SETTLE_CYC+1 cycles.

Reset
REQ-028 While rst = 1, the state SHALL be IDLE and every output SHALL be 0 (ch_sel 0, res_* 0, busy 0); this SHALL also apply mid-scan, abandoning any pending result.

Structure
REQ-029 The state encoding and the default timing constants SHALL be placed in the shared package us_pkg.
REQ-030 Peak/tof tracking SHALL be a sub-module echo_peak_track (clear, sample, threshold in; peak, tof, hit out).

Verification
REQ-031 Test parameters are N_CH = 4, SETTLE = 2, BLANK = 10, WINDOW = 100, threshold 1000. Scenario 1: ch_enable 4'b0101, peak 5000 at tof 40 -> two results: ch 0 and ch 2, hit 1, tof 40, peak 5000, then scan_done.
REQ-032 Scenario 2: samples 1200 at tof 20 and 1200 at tof 30 -> tof 20 (tie keeps the earlier sample); with EARLY_STOP = 1, listen falls after tof 20.
REQ-033 Scenario 3: max sample 999, plus a sample of 9000 at tof 5 during BLANK -> hit 0, tof all-ones, peak 999.
REQ-034 Scenario 4: res_ready held low 50 cycles -> res_valid and payload stable throughout, no next launch until transfer.
REQ-035 Scenario 5: ch_enable 0 -> scan_done one cycle later, no launch_cmd; scan_start while busy -> ignored.
REQ-036 Scenario 6: rst asserted during LISTEN -> next cycle all outputs 0, IDLE; a new scan then runs normally.
